div_unit: RTL

- Iterative RV64M divide/remainder unit: DIV, DIVU, REM, REMU and the W forms DIVW, DIVUW, REMW, REMUW.
- Radix-2 restoring division, one quotient bit per cycle.
- Sits beside the single-cycle ALU in EX. Takes the same CorePack::data_t operands and returns data_t results through valid/ready handshakes.
- The pipeline stalls EX while the unit is busy.

---
 rtl/div_unit_pkg.sv | 35 +++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit_step.sv | 21 ++
 rtl/div_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Core-wide shared types for the EX stage: operand type, ALU/divider op codes,
// divider FSM states and iteration counts.
package CorePack;

    typedef logic [63:0] data_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_enum;

    typedef enum logic [3:0] {
        DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
    } div_op_enum;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DIV_ITER_64 = 64;
    localparam int DIV_ITER_32 = 32;

    function automatic logic op_is_w(div_op_enum op);
        return op inside {DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic op_is_rem(div_op_enum op);
        return op inside {REM, REMU, REMW, REMUW};
    endfunction

    function automatic logic op_is_signed(div_op_enum op);
        return op inside {DIV, REM, DIVW, REMW};
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake bundle between EX issue logic and the divider.
interface div_unit_if;
    import CorePack::*;

    logic       flush;
    logic       in_valid;
    logic       in_ready;
    data_t      a;
    data_t      b;
    div_op_enum div_op;
    logic       out_valid;
    logic       out_ready;
    data_t      res;

    modport master (
        output flush, in_valid, a, b, div_op, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  flush, in_valid, a, b, div_op, out_ready,
        output in_ready, out_valid, res
    );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, subtract the
// divisor if it fits.
module div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem,
    input  logic         dvd_bit,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] shifted;
    logic [W:0] diff;

    // Shifted remainder is < 2*divisor, so one extra bit holds it and the
    // borrow out of that bit says the divisor did not fit.
    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {1'b0, dvs};
    assign q_bit    = ~diff[W];
    assign rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/div_unit.sv
// Iterative RV64M divide/remainder unit, one quotient bit per cycle, with
// operand conditioning, special-case handling and sign fix-up.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rstn,
    div_unit_if.slave   io
);
    import CorePack::*;

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_q, dvd_q, dvs_q, res_q;
    logic            neg_q, neg_r, rem_op, w_op, spec_q;

    logic            is_w, is_rem, is_sgn, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0] a_x, b_x, a_mag, b_mag, a_res, dvd_init, spec_res;

    always_comb begin
        is_w   = op_is_w(io.div_op);
        is_rem = op_is_rem(io.div_op);
        is_sgn = op_is_signed(io.div_op);

        a_neg  = is_sgn & (is_w ? io.a[HALF-1] : io.a[XLEN-1]);
        b_neg  = is_sgn & (is_w ? io.b[HALF-1] : io.b[XLEN-1]);
        a_x    = is_w ? {{HALF{a_neg}}, io.a[HALF-1:0]} : io.a;
        b_x    = is_w ? {{HALF{b_neg}}, io.b[HALF-1:0]} : io.b;
        a_mag  = a_neg ? -a_x : a_x;
        b_mag  = b_neg ? -b_x : b_x;

        // W dividends are left-aligned so the step always consumes bit XLEN-1.
        dvd_init = is_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;

        b_zero = is_w ? (io.b[HALF-1:0] == '0) : (io.b == '0);
        ovf    = is_sgn & (is_w
                 ? ((io.a[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) & (&io.b[HALF-1:0]))
                 : ((io.a == {1'b1, {(XLEN-1){1'b0}}}) & (&io.b)));

        a_res    = is_w ? {{HALF{io.a[HALF-1]}}, io.a[HALF-1:0]} : io.a;
        spec_res = b_zero ? (is_rem ? a_res : '1) : (is_rem ? '0 : a_res);
    end

    logic [XLEN-1:0] rem_next, q_full, q_fix, r_fix, fin, fin_res;
    logic            q_bit;

    div_step #(.W(XLEN)) u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[XLEN-1]),
        .dvs      (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        q_full  = {dvd_q[XLEN-2:0], q_bit};
        q_fix   = neg_q ? -q_full : q_full;
        r_fix   = neg_r ? -rem_next : rem_next;
        fin     = rem_op ? r_fix : q_fix;
        fin_res = w_op ? {{HALF{fin[HALF-1]}}, fin[HALF-1:0]} : fin;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            count  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            res_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            rem_op <= 1'b0;
            w_op   <= 1'b0;
            spec_q <= 1'b0;
        end else if (io.flush) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: if (io.in_valid) begin
                    rem_op <= is_rem;
                    w_op   <= is_w;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    state  <= ST_BUSY;
                    // Special results are parked in rem_q and spend one BUSY
                    // cycle so they surface one edge after accept.
                    if (b_zero | ovf) begin
                        spec_q <= 1'b1;
                        rem_q  <= spec_res;
                        count  <= CW'(1);
                    end else begin
                        spec_q <= 1'b0;
                        rem_q  <= '0;
                        dvd_q  <= dvd_init;
                        dvs_q  <= b_mag;
                        count  <= is_w ? CW'(DIV_ITER_32) : CW'(DIV_ITER_64);
                    end
                end
                ST_BUSY: begin
                    count <= count - CW'(1);
                    if (spec_q) begin
                        res_q <= rem_q;
                        state <= ST_DONE;
                    end else begin
                        rem_q <= rem_next;
                        dvd_q <= q_full;
                        if (count == CW'(1)) begin
                            res_q <= fin_res;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: if (io.out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == ST_IDLE);
    assign io.out_valid = (state == ST_DONE);
    assign io.res       = res_q;
endmodule
